// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the IF stage.
// Request states, queue entry layout and PC helper.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam int          FETCH_DEPTH    = 2;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_WAIT   = 2'd1,
    FS_SQUASH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small circular FIFO of fetched words.
// Flush drops every entry, including a same-cycle push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FETCH_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // qualify push/pop against occupancy
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push &&
              ((count_q < CW'(DEPTH)) || do_pop);
  end

  // next pointers, count and storage
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // queue state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF front end, PC owner and imem requester.
// Handles redirects with one delay slot and squashes wrong path.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic          im_req_q, im_req_d;
  logic [31:0]   im_addr_q, im_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          pend_vld_q, pend_vld_d;
  logic [31:0]   pend_pc_q, pend_pc_d;

  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;
  logic          head_vld;
  logic          ack, redir, pop, push;
  logic          case_a, case_b, case_c;
  logic          may_issue, issue, squash;
  logic [CW:0]   cnt_next;
  logic [31:0]   base_pc;
  logic          pend_v_eff;
  logic [31:0]   pend_pc_eff;

  // classify this cycle's events
  always_comb begin
    head_vld = q_count != '0;
    ack      = im_ack && (state_q != FS_IDLE);
    redir    = redirect_valid && !id_stall;
    pop      = head_vld && !id_stall;
    case_a   = redir && head_vld;
    case_b   = redir && !head_vld &&
               (state_q == FS_WAIT);
    case_c   = redir && !head_vld &&
               (state_q != FS_WAIT);
    push     = ack && (state_q == FS_WAIT) &&
               !case_a;
    q_in     = '{pc: im_addr_q, instr: im_rdata};
    cnt_next = case_a ? '0 :
               {1'b0, q_count} +
               {{CW{1'b0}}, push} -
               {{CW{1'b0}}, pop};
    may_issue = (state_q == FS_IDLE) || ack;
    issue     = may_issue &&
                (cnt_next < (CW+1)'(DEPTH));
    squash    = case_a && !may_issue;
  end

  // request FSM next state
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      may_issue: state_d = issue ? FS_WAIT
                                 : FS_IDLE;
      squash:    state_d = FS_SQUASH;
      default:   state_d = state_q;
    endcase
  end

  // request outputs, fetch PC and pending target
  always_comb begin
    base_pc     = (case_a || case_b) ? redirect_pc
                                     : fetch_pc_q;
    pend_v_eff  = case_c ? 1'b1 :
                  (case_a || case_b) ? 1'b0 :
                  pend_vld_q;
    pend_pc_eff = case_c ? redirect_pc : pend_pc_q;
    im_req_d    = im_req_q;
    im_addr_d   = im_addr_q;
    fetch_pc_d  = base_pc;
    pend_vld_d  = pend_v_eff;
    pend_pc_d   = pend_pc_eff;
    if (may_issue) begin
      im_req_d = issue;
      if (issue) begin
        im_addr_d  = base_pc;
        fetch_pc_d = pend_v_eff ? pend_pc_eff
                                : pc_next(base_pc);
        pend_vld_d = 1'b0;
      end
    end
  end

  // state and request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      im_req_q   <= 1'b0;
      im_addr_q  <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      im_req_q   <= im_req_d;
      im_addr_q  <= im_addr_d;
      fetch_pc_q <= fetch_pc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (q_in),
    .pop        (pop),
    .flush      (case_a),
    .count      (q_count),
    .head       (q_head)
  );

  // present queue head to ID, zero when empty
  always_comb begin
    im_req   = im_req_q;
    im_addr  = im_addr_q;
    if_valid = head_vld;
    if_instr = head_vld ? q_head.instr : '0;
    if_pc    = head_vld ? q_head.pc    : '0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for the IF stage.
// Bench memory has programmable latency and resets with the DUT.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int lat = 0;
  int wait_cnt;
  int n_run = 0;
  int n_fail = 0;
  int n_ack = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_3000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  function automatic logic [31:0] instr_of(
    input logic [31:0] a
  );
    return a ^ 32'hA5A5_0F0F;
  endfunction

  assign im_ack   = im_req && (wait_cnt >= lat);
  assign im_rdata = instr_of(im_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (im_req && im_ack) wait_cnt <= 0;
    else if (im_req) wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] e;
    if (if_valid && !id_stall) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra_pop", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_instr", if_instr, instr_of(e));
      end
    end
    if (im_req && im_ack) n_ack++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      cycle();
      n++;
    end
    chk(tag, sb_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_im_req", im_req, 0);
    chk("rst_im_addr", im_addr, 32'h3000);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_head(
    input string       tag,
    input logic [31:0] pc
  );
    int n = 0;
    while (!(if_valid && if_pc == pc) && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, n < 40, 1);
  endtask

  initial begin
    int n;
    #2;

    lat = 0; id_stall = 0;
    do_reset();
    for (int k = 0; k < 8; k++)
      sb_q.push_back(32'h3000 + 4 * k);
    cycle();
    for (int i = 0; i < 8; i++) begin
      chk("s1_req", im_req, 1);
      chk("s1_addr", im_addr, 32'h3000 + 4 * i);
      if (i > 0) chk("s1_valid", if_valid, 1);
      cycle();
    end
    drain("s1_drain");

    lat = 2; id_stall = 1;
    do_reset();
    n_ack = 0;
    repeat (12) cycle();
    chk("s2_acks", n_ack, 2);
    chk("s2_req_off", im_req, 0);
    chk("s2_valid", if_valid, 1);
    chk("s2_head", if_pc, 32'h3000);
    sb_q = '{32'h3000, 32'h3004,
             32'h3008, 32'h300C};
    id_stall = 0;
    cycle();
    chk("s2_resume_req", im_req, 1);
    chk("s2_resume_addr", im_addr, 32'h3008);
    drain("s2_drain");

    lat = 2; id_stall = 0;
    do_reset();
    sb_q = '{32'h3000, 32'h3004, 32'h3008,
             32'h3100, 32'h3104, 32'h3108};
    wait_head("s3_reach", 32'h3008);
    chk("s3_out_req", im_req, 1);
    chk("s3_out_addr", im_addr, 32'h300C);
    redirect_valid = 1; redirect_pc = 32'h3100;
    cycle();
    redirect_valid = 0;
    drain("s3_drain");

    lat = 2; id_stall = 0;
    do_reset();
    sb_q = '{32'h3000, 32'h3004, 32'h3008,
             32'h3100, 32'h3104};
    n = 0;
    while (!(im_req && im_addr == 32'h3008 &&
             !if_valid) && n < 40) begin
      cycle();
      n++;
    end
    chk("s4_reach", n < 40, 1);
    redirect_valid = 1; redirect_pc = 32'h3100;
    cycle();
    redirect_valid = 0;
    drain("s4_drain");

    lat = 0; id_stall = 0;
    do_reset();
    sb_q = '{32'h3000, 32'h3100,
             32'h3104, 32'h3108};
    chk("s5_idle", im_req, 0);
    redirect_valid = 1; redirect_pc = 32'h3100;
    cycle();
    redirect_valid = 0;
    chk("s5_slot_addr", im_addr, 32'h3000);
    cycle();
    chk("s5_tgt_addr", im_addr, 32'h3100);
    drain("s5_drain");

    lat = 2; id_stall = 0;
    do_reset();
    sb_q = '{32'h3000, 32'h3004, 32'h3008,
             32'h3100, 32'h3104, 32'h3108};
    wait_head("s6_reach", 32'h3008);
    redirect_valid = 1; redirect_pc = 32'h3100;
    id_stall = 1;
    repeat (2) cycle();
    chk("s6_hold_valid", if_valid, 1);
    chk("s6_hold_pc", if_pc, 32'h3008);
    chk("s6_ack_now", im_ack, 1);
    id_stall = 0;
    cycle();
    redirect_valid = 0;
    chk("s6_tgt_req", im_req, 1);
    chk("s6_tgt_addr", im_addr, 32'h3100);
    chk("s6_flushed", if_valid, 0);
    drain("s6_drain");

    lat = 1; id_stall = 1;
    do_reset();
    n = 0;
    while (!(if_valid && im_req) && n < 40) begin
      cycle();
      n++;
    end
    chk("s7_reach", n < 40, 1);
    chk("s7_busy_addr", im_addr, 32'h3004);
    do_reset();
    lat = 0; id_stall = 0;
    sb_q = '{32'h3000, 32'h3004, 32'h3008};
    cycle();
    chk("s7_first_req", im_req, 1);
    chk("s7_first_addr", im_addr, 32'h3000);
    drain("s7_drain");

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
